// File: rtl/cache_pkg.sv
// Shared cache memory-bus definitions: request opcodes and bus widths.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH = 8;

  typedef logic [ADDR_WIDTH-1:0] UbitAddr;
  typedef logic [DATA_WIDTH-1:0] UbitData;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } Op;

endpackage

// File: rtl/main_mem_if.sv
// Cache memory bus: requester drives op/addr/data, memory returns a one-cycle response strobe.
interface MemBus;
  import cache_pkg::*;

  Op       req_op;
  UbitAddr req_addr;
  UbitData req_data;
  logic    rsp_vld;
  UbitData rsp_data;

  modport rx_bp (
    input  req_op,
    input  req_addr,
    input  req_data,
    output rsp_vld,
    output rsp_data
  );

  modport tx_bp (
    output req_op,
    output req_addr,
    output req_data,
    input  rsp_vld,
    input  rsp_data
  );

endinterface

// File: rtl/main_mem_array.sv
// Single-port word storage: synchronous write, asynchronous read. Contents are never reset.
module main_mem_array
  import cache_pkg::*;
#(
  parameter int unsigned DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  UbitData                  wdata,
  output UbitData                  rdata
);

  UbitData mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/main_mem.sv
// Memory-side responder: one request at a time, response strobe LATENCY cycles after the request.
// Define MAIN_MEM_ASSERT_EN to compile in protocol assertions.
module main_mem
  import cache_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 2 ** ADDR_WIDTH
) (
  input logic   clk,
  input logic   rst,
  MemBus.rx_bp  bus
);

  localparam int unsigned CntWidth = $clog2(LATENCY + 1);
  localparam int unsigned IdxWidth = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } MemState;

  MemState             state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  UbitData             rsp_q, rsp_d;

  logic                accept;
  logic                arr_we;
  logic [IdxWidth-1:0] arr_addr;
  UbitData             arr_rdata;

  // Address is taken modulo DEPTH so a shallow array still accepts full bus addresses.
  assign arr_addr = IdxWidth'(32'(bus.req_addr) % DEPTH);
  assign accept   = !rst && (state_q == StIdle || state_q == StResp) && (bus.req_op != OP_NOP);
  assign arr_we   = accept && (bus.req_op == OP_WRITE);

  main_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (bus.req_data),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          cnt_d   = CntWidth'(LATENCY - 1);
          rsp_d   = (bus.req_op == OP_WRITE) ? bus.req_data : arr_rdata;
          state_d = (LATENCY > 1) ? StWait : StResp;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntWidth'(1)) begin
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.rsp_vld  = (state_q == StResp);
  assign bus.rsp_data = (state_q == StResp) ? rsp_q : '0;

`ifdef MAIN_MEM_ASSERT_EN
  a_nop_in_wait: assert property (@(posedge clk) disable iff (rst)
    (state_q == StWait) |-> (bus.req_op == OP_NOP))
    else $error("[%0t] main_mem: request presented while a response is pending", $time);

  a_op_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(bus.req_op))
    else $error("[%0t] main_mem: req_op is X/Z", $time);

  // With LATENCY=1 legal back-to-back traffic strobes every cycle, so the check only applies above 1.
  if (LATENCY > 1) begin : g_vld_pulse
    a_vld_pulse: assert property (@(posedge clk) disable iff (rst)
      bus.rsp_vld |=> !bus.rsp_vld)
      else $error("[%0t] main_mem: rsp_vld high for two consecutive cycles", $time);
  end
`endif

endmodule

// File: tb/tb_main_mem.sv
// Bench for main_mem: three instances (latency 4, latency 1, 16-word) against a word-array model.
module tb_main_mem;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  UbitData ref_mem [3][64];
  bit      written [3][64];

  always #5 clk = ~clk;

  MemBus bus4 ();
  MemBus bus1 ();
  MemBus bus16 ();

  main_mem #(.LATENCY(4), .DEPTH(64)) dut4  (.clk(clk), .rst(rst), .bus(bus4));
  main_mem #(.LATENCY(1), .DEPTH(64)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
  main_mem #(.LATENCY(3), .DEPTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 3;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 2) ? 16 : 64;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input Op op, input UbitAddr a, input UbitData w);
    case (d)
      0:       begin bus4.req_op = op;  bus4.req_addr = a;  bus4.req_data = w;  end
      1:       begin bus1.req_op = op;  bus1.req_addr = a;  bus1.req_data = w;  end
      default: begin bus16.req_op = op; bus16.req_addr = a; bus16.req_data = w; end
    endcase
  endtask

  function automatic logic [8:0] peek(input int d);
    case (d)
      0:       return {bus4.rsp_vld, bus4.rsp_data};
      1:       return {bus1.rsp_vld, bus1.rsp_data};
      default: return {bus16.rsp_vld, bus16.rsp_data};
    endcase
  endfunction

  task automatic sample(input int d, input string tag, input bit ev, input UbitData ed);
    logic [8:0] o;
    o = peek(d);
    check({tag, ".vld"}, 32'(o[8]), 32'(ev));
    check({tag, ".data"}, 32'(o[7:0]), ev ? 32'(ed) : 32'd0);
  endtask

  // Memory model: writes update the word and echo the data, reads return the stored word.
  function automatic UbitData model(input int d, input Op op, input UbitAddr a, input UbitData w);
    int idx;
    idx = int'(a) % dep_of(d);
    if (op == OP_WRITE) begin
      ref_mem[d][idx] = w;
      written[d][idx] = 1'b1;
      return w;
    end
    return ref_mem[d][idx];
  endfunction

  // Called at a falling edge; returns at the falling edge inside the expected response cycle,
  // so a following call issues back-to-back in that cycle.
  task automatic xact(input int d, input Op op, input UbitAddr a, input UbitData w,
                      input string tag);
    UbitData e;
    int      l;
    e = model(d, op, a, w);
    l = lat_of(d);
    drive(d, op, a, w);
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      if (k == 1) drive(d, OP_NOP, '0, '0);
      sample(d, tag, k == l, e);
    end
  endtask

  task automatic idle(input int d, input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      sample(d, tag, 1'b0, '0);
    end
  endtask

  initial begin
    UbitData e;
    int      vcount;
    Op       op;
    UbitAddr a;
    UbitData w;

    for (int d = 0; d < 3; d++) drive(d, OP_NOP, '0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) sample(d, "reset", 1'b0, '0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) sample(d, "idle", 1'b0, '0);
    end

    // Latency 4: write then back-to-back read of the same word.
    xact(0, OP_WRITE, 6'h05, 8'hA5, "l4_wr05");
    xact(0, OP_READ, 6'h05, 8'h00, "l4_rd05");
    idle(0, 2, "l4_gap");

    // Latency 1: each request issued in the response cycle of the previous one.
    xact(1, OP_WRITE, 6'h3F, 8'h11, "l1_wr11");
    xact(1, OP_READ, 6'h3F, 8'h00, "l1_rd11");
    xact(1, OP_WRITE, 6'h3F, 8'h22, "l1_wr22");
    xact(1, OP_READ, 6'h3F, 8'h00, "l1_rd22");
    idle(1, 2, "l1_gap");

    // A read driven while the write is pending must be ignored.
    e = model(0, OP_WRITE, 6'h10, 8'h77);
    drive(0, OP_WRITE, 6'h10, 8'h77);
    vcount = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, OP_READ, 6'h10, 8'h00);
      else if (k == 2) drive(0, OP_NOP, '0, '0);
      sample(0, "wait_ign", k == 4, e);
      vcount += int'(peek(0) >> 8);
    end
    check("wait_ign.count", 32'(vcount), 32'd1);

    // Reset two cycles into a read drops the response; array survives.
    drive(0, OP_READ, 6'h05, 8'h00);
    @(negedge clk);
    drive(0, OP_NOP, '0, '0);
    sample(0, "rst_mid0", 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    sample(0, "rst_mid1", 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    sample(0, "rst_mid2", 1'b0, '0);
    idle(0, 6, "rst_drop");
    xact(0, OP_READ, 6'h05, 8'h00, "rst_keep");

    // A write presented together with reset is not accepted.
    rst = 1'b1;
    drive(0, OP_WRITE, 6'h05, 8'hEE);
    @(negedge clk);
    rst = 1'b0;
    drive(0, OP_NOP, '0, '0);
    sample(0, "rst_req", 1'b0, '0);
    idle(0, 6, "rst_req_idle");
    xact(0, OP_READ, 6'h05, 8'h00, "rst_req_rd");

    // 16-word instance: address 0x13 aliases word 3.
    xact(2, OP_WRITE, 6'h13, 8'h5C, "wrap_wr");
    xact(2, OP_READ, 6'h03, 8'h00, "wrap_rd");
    idle(2, 1, "wrap_gap");

    // Random traffic; reads only target words already written.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 40; i++) begin
        op = ($urandom_range(0, 1) == 0) ? OP_WRITE : OP_READ;
        a  = UbitAddr'($urandom);
        w  = UbitData'($urandom);
        if (op == OP_READ && !written[d][int'(a) % dep_of(d)]) op = OP_WRITE;
        xact(d, op, a, w, $sformatf("rnd%0d_%0d", d, i));
        if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(1, 2), "rnd_gap");
      end
      idle(d, 1, "rnd_end");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
